// File: rtl/noc_network_interface.sv
// Network interface between a core and a mesh router LOCAL port.
// Injection FIFO + IDLE/NOC/LOOP output stage, ejection FIFO shared with loopback.
module noc_network_interface #(
   parameter int                    DATA_WIDTH = 256,
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    TX_DEPTH   = 4,
   parameter int                    RX_DEPTH   = 4,
   parameter logic [ADDR_WIDTH-1:0] NODE_ID    = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [ADDR_WIDTH-1:0] tx_dest,
   input  logic [2:0]            tx_type,
   output logic                  noc_valid_out,
   input  logic                  noc_ready_in,
   output logic [DATA_WIDTH-1:0] noc_data_out,
   output logic [ADDR_WIDTH-1:0] noc_dest_out,
   output logic [2:0]            noc_type_out,
   input  logic                  noc_valid_in,
   output logic                  noc_ready_out,
   input  logic [DATA_WIDTH-1:0] noc_data_in,
   input  logic [ADDR_WIDTH-1:0] noc_dest_in,
   input  logic [2:0]            noc_type_in,
   output logic                  rx_valid,
   input  logic                  rx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic [2:0]            rx_type,
   output logic                  misroute_pulse,
   output logic [15:0]           tx_pkt_count,
   output logic [15:0]           rx_pkt_count,
   output logic [15:0]           drop_count
);

   localparam int TW  = DATA_WIDTH + ADDR_WIDTH + 3;
   localparam int RW  = DATA_WIDTH + 3;
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);
   localparam logic [TAW:0] TX_FULL = (TAW+1)'(TX_DEPTH);
   localparam logic [RAW:0] RX_FULL = (RAW+1)'(RX_DEPTH);

   typedef enum logic [1:0] {IDLE, NOC, LOOP} state_t;

   state_t state, state_d;

   logic [TW-1:0]  tx_mem [TX_DEPTH];
   logic [TAW-1:0] tx_wr, tx_rd;
   logic [TAW:0]   tx_cnt;
   logic [RW-1:0]  rx_mem [RX_DEPTH];
   logic [RAW-1:0] rx_wr, rx_rd;
   logic [RAW:0]   rx_cnt;

   logic                  tx_push, tx_pop, loop_wr;
   logic                  rx_push, rx_pop, rx_free;
   logic                  eject_hs, eject_wr, drop_evt, tx_evt;
   logic                  mis_q;
   logic [TW-1:0]         head;
   logic [ADDR_WIDTH-1:0] nxt_dest;
   logic [RW-1:0]         rx_wdata, rx_head;

   assign head     = tx_mem[tx_rd];
   assign nxt_dest = tx_mem[tx_rd + TAW'(1)][DATA_WIDTH +: ADDR_WIDTH];

   assign tx_ready = !rst && (tx_cnt != TX_FULL);
   assign tx_push  = tx_valid && tx_ready;

   // Free space is judged after this cycle's core pop
   assign rx_valid      = !rst && (rx_cnt != '0);
   assign rx_pop        = rx_valid && rx_ready;
   assign rx_free       = (rx_cnt - {{RAW{1'b0}}, rx_pop}) != RX_FULL;
   assign noc_ready_out = !rst && rx_free;

   assign eject_hs = noc_valid_in && noc_ready_out;
   assign eject_wr = eject_hs && (noc_dest_in == NODE_ID);
   assign drop_evt = eject_hs && (noc_dest_in != NODE_ID);

   assign rx_push  = eject_wr || loop_wr;
   assign rx_wdata = eject_wr ? {noc_type_in, noc_data_in}
                              : {head[TW-1 -: 3], head[DATA_WIDTH-1:0]};

   always_comb begin
      state_d = state;
      tx_pop  = 1'b0;
      loop_wr = 1'b0;
      case (state)
         IDLE:
            if (tx_cnt != '0)
               state_d = (head[DATA_WIDTH +: ADDR_WIDTH] == NODE_ID) ? LOOP : NOC;
         NOC:
            tx_pop = noc_ready_in;
         LOOP: begin
            loop_wr = !rst && rx_free && !eject_hs;
            tx_pop  = loop_wr;
         end
         default:
            state_d = IDLE;
      endcase
      // Chain straight into the next head to sustain one flit per cycle
      if (tx_pop) begin
         if (tx_cnt > (TAW+1)'(1))
            state_d = (nxt_dest == NODE_ID) ? LOOP : NOC;
         else if (tx_push)
            state_d = (tx_dest == NODE_ID) ? LOOP : NOC;
         else
            state_d = IDLE;
      end
   end

   assign tx_evt = (noc_valid_out && noc_ready_in) || loop_wr;

   assign noc_valid_out = !rst && (state == NOC);
   assign noc_data_out  = noc_valid_out ? head[DATA_WIDTH-1:0] : '0;
   assign noc_dest_out  = noc_valid_out ? head[DATA_WIDTH +: ADDR_WIDTH] : '0;
   assign noc_type_out  = noc_valid_out ? head[TW-1 -: 3] : '0;

   assign rx_head = rx_mem[rx_rd];
   assign rx_data = rx_valid ? rx_head[DATA_WIDTH-1:0] : '0;
   assign rx_type = rx_valid ? rx_head[RW-1 -: 3] : '0;

   assign misroute_pulse = mis_q && !rst;

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wr] <= {tx_type, tx_dest, tx_data};
      if (rx_push) rx_mem[rx_wr] <= rx_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         tx_wr        <= '0;
         tx_rd        <= '0;
         tx_cnt       <= '0;
         rx_wr        <= '0;
         rx_rd        <= '0;
         rx_cnt       <= '0;
         mis_q        <= 1'b0;
         tx_pkt_count <= '0;
         rx_pkt_count <= '0;
         drop_count   <= '0;
      end else begin
         state  <= state_d;
         tx_wr  <= tx_wr + TAW'(tx_push);
         tx_rd  <= tx_rd + TAW'(tx_pop);
         tx_cnt <= tx_cnt + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);
         rx_wr  <= rx_wr + RAW'(rx_push);
         rx_rd  <= rx_rd + RAW'(rx_pop);
         rx_cnt <= rx_cnt + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
         mis_q  <= drop_evt;
         if (tx_evt && tx_pkt_count != 16'hFFFF)
            tx_pkt_count <= tx_pkt_count + 16'd1;
         if (rx_pop && rx_pkt_count != 16'hFFFF)
            rx_pkt_count <= rx_pkt_count + 16'd1;
         if (drop_evt && drop_count != 16'hFFFF)
            drop_count <= drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_noc_network_interface.sv
// Directed and randomized checks of noc_network_interface
// against queue-based packet scoreboards.
module tb_noc_network_interface;

   localparam int DW = 256;
   localparam int AW = 16;
   localparam logic [AW-1:0] ME = 16'h0101;

   logic          clk = 1'b0;
   logic          rst;
   logic          tx_valid, tx_ready;
   logic [DW-1:0] tx_data;
   logic [AW-1:0] tx_dest;
   logic [2:0]    tx_type;
   logic          noc_valid_out, noc_ready_in;
   logic [DW-1:0] noc_data_out;
   logic [AW-1:0] noc_dest_out;
   logic [2:0]    noc_type_out;
   logic          noc_valid_in, noc_ready_out;
   logic [DW-1:0] noc_data_in;
   logic [AW-1:0] noc_dest_in;
   logic [2:0]    noc_type_in;
   logic          rx_valid, rx_ready;
   logic [DW-1:0] rx_data;
   logic [2:0]    rx_type;
   logic          misroute_pulse;
   logic [15:0]   tx_pkt_count, rx_pkt_count, drop_count;

   noc_network_interface #(.NODE_ID(ME)) dut (
      .clk(clk), .rst(rst),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
      .tx_dest(tx_dest), .tx_type(tx_type),
      .noc_valid_out(noc_valid_out), .noc_ready_in(noc_ready_in),
      .noc_data_out(noc_data_out), .noc_dest_out(noc_dest_out),
      .noc_type_out(noc_type_out),
      .noc_valid_in(noc_valid_in), .noc_ready_out(noc_ready_out),
      .noc_data_in(noc_data_in), .noc_dest_in(noc_dest_in),
      .noc_type_in(noc_type_in),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
      .rx_type(rx_type), .misroute_pulse(misroute_pulse),
      .tx_pkt_count(tx_pkt_count), .rx_pkt_count(rx_pkt_count),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [511:0] got,
                      input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      tx_valid = 0; tx_data = '0; tx_dest = '0; tx_type = '0;
      noc_ready_in = 0;
      noc_valid_in = 0; noc_data_in = '0; noc_dest_in = '0; noc_type_in = '0;
      rx_ready = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1;
      tick();
      tick();
      rst = 0;
      #1;
   endtask

   // Scoreboard: packets expected at each egress, in order
   typedef logic [DW+AW+2:0] noc_pkt_t;
   typedef logic [DW+2:0]    rx_pkt_t;
   noc_pkt_t exp_noc[$];
   rx_pkt_t  exp_loop[$];
   rx_pkt_t  exp_ej[$];
   int       n_noc, n_loop, n_rx, n_drop;
   logic     exp_mis;
   logic     tx_hs, ej_hs;

   task automatic step();
      #2;
      chk("misroute", misroute_pulse, exp_mis);
      tx_hs = tx_valid && tx_ready;
      ej_hs = noc_valid_in && noc_ready_out;
      exp_mis = ej_hs && (noc_dest_in != ME);
      if (tx_hs) begin
         if (tx_dest == ME) begin
            exp_loop.push_back({tx_type, tx_data});
            n_loop++;
         end else
            exp_noc.push_back({tx_type, tx_dest, tx_data});
      end
      if (ej_hs) begin
         if (noc_dest_in == ME) exp_ej.push_back({noc_type_in, noc_data_in});
         else n_drop++;
      end
      if (noc_valid_out && noc_ready_in) begin
         n_noc++;
         chk("noc_avail", exp_noc.size() != 0, 1'b1);
         if (exp_noc.size() != 0)
            chk("noc_flit", {noc_type_out, noc_dest_out, noc_data_out},
                exp_noc.pop_front());
      end
      if (rx_valid && rx_ready) begin
         n_rx++;
         if (exp_loop.size() != 0 && {rx_type, rx_data} == exp_loop[0])
            chk("rx_loop", {rx_type, rx_data}, exp_loop.pop_front());
         else begin
            chk("rx_avail", exp_ej.size() != 0, 1'b1);
            if (exp_ej.size() != 0)
               chk("rx_eject", {rx_type, rx_data}, exp_ej.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      return {8{$urandom()}};
   endfunction

   initial begin
      idle_inputs();

      // reset behaviour
      rst = 1;
      tx_valid = 1; tx_dest = 16'h0203; noc_valid_in = 1;
      tick();
      chk("rst_tx_ready", tx_ready, 1'b0);
      chk("rst_noc_ready_out", noc_ready_out, 1'b0);
      chk("rst_noc_valid_out", noc_valid_out, 1'b0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_misroute", misroute_pulse, 1'b0);
      chk("rst_counts", {tx_pkt_count, rx_pkt_count, drop_count}, 48'h0);
      chk("rst_data", {noc_data_out, rx_data}, '0);
      idle_inputs();
      tick();
      rst = 0;
      #1;
      chk("post_rst_tx_ready", tx_ready, 1'b1);
      chk("post_rst_noc_ready_out", noc_ready_out, 1'b1);

      // single remote packet
      do_reset();
      noc_ready_in = 1;
      tx_valid = 1; tx_dest = 16'h0203; tx_data = 256'hA5; tx_type = 3'd2;
      #1 chk("single_accept", tx_ready, 1'b1);
      tick();
      tx_valid = 0;
      chk("single_not_yet", noc_valid_out, 1'b0);
      tick();
      chk("single_valid", noc_valid_out, 1'b1);
      chk("single_dest", noc_dest_out, 16'h0203);
      chk("single_data", noc_data_out, 256'hA5);
      chk("single_type", noc_type_out, 3'd2);
      tick();
      chk("single_count", tx_pkt_count, 16'd1);
      chk("single_done", noc_valid_out, 1'b0);

      // backpressure: 4 accepted, then drained back-to-back
      do_reset();
      tx_dest = 16'h0203;
      for (int i = 0; i < 5; i++) begin
         tx_valid = 1; tx_data = DW'(100 + i);
         #1 chk($sformatf("bp_ready%0d", i), tx_ready, i < 4);
         tick();
      end
      tx_valid = 0;
      noc_ready_in = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("bp_valid%0d", i), noc_valid_out, 1'b1);
         chk($sformatf("bp_data%0d", i), noc_data_out, DW'(100 + i));
         tick();
      end
      chk("bp_empty", noc_valid_out, 1'b0);
      chk("bp_count", tx_pkt_count, 16'd4);

      // loopback with no ejection traffic
      do_reset();
      tx_valid = 1; tx_dest = ME; tx_data = 256'h1B; tx_type = 3'd5;
      tick();
      tx_valid = 0;
      chk("loop_rx0", rx_valid, 1'b0);
      tick();
      chk("loop_noc1", noc_valid_out, 1'b0);
      tick();
      chk("loop_noc2", noc_valid_out, 1'b0);
      chk("loop_rx_valid", rx_valid, 1'b1);
      chk("loop_rx_data", rx_data, 256'h1B);
      chk("loop_rx_type", rx_type, 3'd5);
      chk("loop_count", tx_pkt_count, 16'd1);

      // loopback held off by continuous ejection
      do_reset();
      rx_ready = 1;
      noc_valid_in = 1; noc_dest_in = ME; noc_data_in = 256'hE0;
      tx_valid = 1; tx_dest = ME; tx_data = 256'h2C;
      tick();
      tx_valid = 0;
      repeat (6) tick();
      chk("loop_wait_count", tx_pkt_count, 16'd0);
      chk("loop_wait_rx", rx_pkt_count, 16'd6);
      noc_valid_in = 0;
      tick();
      chk("loop_late_count", tx_pkt_count, 16'd1);
      chk("loop_late_data", rx_data, 256'h2C);

      // misrouted ejection
      do_reset();
      noc_valid_in = 1; noc_dest_in = 16'h0303; noc_data_in = 256'h77;
      #1 chk("mis_ready", noc_ready_out, 1'b1);
      tick();
      noc_valid_in = 0;
      chk("mis_pulse", misroute_pulse, 1'b1);
      chk("mis_rx", rx_valid, 1'b0);
      chk("mis_drop", drop_count, 16'd1);
      tick();
      chk("mis_pulse_end", misroute_pulse, 1'b0);

      // RX full, simultaneous pop and ejection
      do_reset();
      noc_dest_in = ME;
      for (int i = 0; i < 4; i++) begin
         noc_valid_in = 1; noc_data_in = DW'(200 + i);
         #1 chk($sformatf("rxf_ready%0d", i), noc_ready_out, 1'b1);
         tick();
      end
      noc_valid_in = 0;
      #1 chk("rxf_full", noc_ready_out, 1'b0);
      rx_ready = 1; noc_valid_in = 1; noc_data_in = DW'(204);
      #1 chk("rxf_pop_ready", noc_ready_out, 1'b1);
      chk("rxf_head", rx_data, DW'(200));
      tick();
      rx_ready = 0; noc_valid_in = 0;
      #1 chk("rxf_still_full", noc_ready_out, 1'b0);
      rx_ready = 1;
      for (int i = 1; i < 5; i++) begin
         #1 chk($sformatf("rxf_data%0d", i), rx_data, DW'(200 + i));
         tick();
      end
      chk("rxf_empty", rx_valid, 1'b0);

      // drop counter saturation
      do_reset();
      noc_valid_in = 1; noc_dest_in = 16'h0303;
      repeat (65535) @(posedge clk);
      #1 chk("sat_reach", drop_count, 16'hFFFF);
      tick();
      chk("sat_hold", drop_count, 16'hFFFF);

      // reset mid-stream
      do_reset();
      tx_dest = 16'h0203; noc_dest_in = ME;
      for (int i = 0; i < 3; i++) begin
         tx_valid = 1; tx_data = rnd_data();
         noc_valid_in = 1; noc_data_in = rnd_data();
         tick();
      end
      rst = 1;
      #1;
      chk("mid_ready_tx", tx_ready, 1'b0);
      chk("mid_ready_rx", noc_ready_out, 1'b0);
      tick();
      chk("mid_valids", {noc_valid_out, rx_valid, misroute_pulse}, 3'b000);
      chk("mid_counts", {tx_pkt_count, rx_pkt_count, drop_count}, 48'h0);
      chk("mid_data", {noc_data_out, rx_data, rx_type}, '0);
      idle_inputs();
      rst = 0;
      noc_ready_in = 1; rx_ready = 1;
      tick();
      tick();
      chk("mid_flushed", {noc_valid_out, rx_valid}, 2'b00);
      chk("mid_no_count", {tx_pkt_count, rx_pkt_count}, 32'h0);

      // randomized traffic against the scoreboard
      do_reset();
      n_noc = 0; n_loop = 0; n_rx = 0; n_drop = 0;
      exp_mis = 0; tx_hs = 0; ej_hs = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!tx_valid || tx_hs) begin
            tx_valid = $urandom_range(0, 1) == 1;
            tx_data  = rnd_data();
            tx_type  = 3'($urandom_range(0, 7));
            tx_dest  = ($urandom_range(0, 2) == 0) ? ME
                     : {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
         end
         if (!noc_valid_in || ej_hs) begin
            noc_valid_in = $urandom_range(0, 2) != 0;
            noc_data_in  = rnd_data();
            noc_type_in  = 3'($urandom_range(0, 7));
            noc_dest_in  = ($urandom_range(0, 7) == 0) ? 16'h0303 : ME;
         end
         noc_ready_in = $urandom_range(0, 3) != 0;
         rx_ready     = $urandom_range(0, 3) != 0;
         step();
      end
      tx_valid = 0; noc_valid_in = 0;
      noc_ready_in = 1; rx_ready = 1;
      repeat (40) step();
      chk("rand_noc_left", exp_noc.size(), 0);
      chk("rand_loop_left", exp_loop.size(), 0);
      chk("rand_ej_left", exp_ej.size(), 0);
      chk("rand_tx_count", tx_pkt_count, 16'(n_noc + n_loop));
      chk("rand_rx_count", rx_pkt_count, 16'(n_rx));
      chk("rand_drop_count", drop_count, 16'(n_drop));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
